// File: rtl/fetch_exec_sequencer.sv
// Multi-cycle fetch/decode/exec/writeback sequencer for the 16-bit Harvard core.
// Sole owner of PC advance, branch-if-zero and halt.
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-low reset
//   start             - begin execution from current pc (sampled in IDLE only)
//   mem_ready         - instr_in valid this cycle
//   instr_in          - instruction memory read data
//   alu_zero          - ALU zero flag, sampled in EXEC
//   pc                - fetch address
//   ir                - latched instruction register
//   alu_en, rf_we     - ALU strobe (EXEC), register write enable (WB)
//   busy, halted      - running / stopped status
//   retired           - saturating count of committed instructions
module fetch_exec_sequencer #(
    parameter int unsigned PC_W     = 6,
    parameter int unsigned INSTR_W  = 32,
    parameter int unsigned CNT_W    = 16,
    parameter logic [5:0]  HALT_OPC = 6'b111111,
    parameter logic [5:0]  BR_OPC   = 6'b110000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mem_ready,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               alu_zero,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] ir,
    output logic               alu_en,
    output logic               rf_we,
    output logic               busy,
    output logic               halted,
    output logic [CNT_W-1:0]   retired
);

    localparam int unsigned OPC_W = 6;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t           state, state_next;
    logic [OPC_W-1:0] opcode;
    logic             br_taken;
    logic             alu_en_d, rf_we_d, busy_d, halted_d;

    assign opcode = ir[INSTR_W-1 -: OPC_W];

    // State register; strobes are registered from the next state so they
    // line up exactly with the state they belong to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            alu_en <= 1'b0;
            rf_we  <= 1'b0;
            busy   <= 1'b0;
            halted <= 1'b0;
        end else begin
            state  <= state_next;
            alu_en <= alu_en_d;
            rf_we  <= rf_we_d;
            busy   <= busy_d;
            halted <= halted_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_FETCH;
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: state_next = (opcode == HALT_OPC) ? S_HALT : S_EXEC;
            S_EXEC:   state_next = S_WB;
            S_WB:     state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_IDLE;
        endcase
    end

    // Output decode from next state (ir is already stable when EXEC->WB is chosen)
    always_comb begin
        alu_en_d = 1'b0;
        rf_we_d  = 1'b0;
        busy_d   = 1'b0;
        halted_d = 1'b0;
        alu_en_d = (state_next == S_EXEC);
        rf_we_d  = (state_next == S_WB) && (opcode != BR_OPC);
        busy_d   = (state_next != S_IDLE) && (state_next != S_HALT);
        halted_d = (state_next == S_HALT);
    end

    // Datapath: instruction latch, branch decision, commit of pc/retired
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= '0;
            ir       <= '0;
            retired  <= '0;
            br_taken <= 1'b0;
        end else begin
            if (state == S_FETCH && mem_ready) begin
                ir <= instr_in;
            end
            if (state == S_EXEC) begin
                br_taken <= (opcode == BR_OPC) && alu_zero;
            end
            if (state == S_WB) begin
                pc <= br_taken ? ir[PC_W-1:0] : pc + PC_W'(1);
                if (retired != '1) begin
                    retired <= retired + CNT_W'(1);
                end
            end
        end
    end

endmodule
